// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped board I/O for the project3 frame.
// Edge-captured keys, debounced switches, LED/7-seg registers and a
// prescaled interval timer behind a 256-byte register window.
module io_ctrl #(
  parameter logic [31:0] IO_BASE         = 32'hF000_0000,
  parameter int          TICK_CYCLES     = 50000,
  parameter int          DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rd_valid,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic        irq
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [7:0] OFF_KDATA = 8'h00;
  localparam logic [7:0] OFF_KCTRL = 8'h04;
  localparam logic [7:0] OFF_SDATA = 8'h10;
  localparam logic [7:0] OFF_TCNT  = 8'h20;
  localparam logic [7:0] OFF_TLIM  = 8'h24;
  localparam logic [7:0] OFF_TCTRL = 8'h28;
  localparam logic [7:0] OFF_LEDR  = 8'h30;
  localparam logic [7:0] OFF_HEX   = 8'h34;

  logic [31:0]   r_rdata;
  logic          r_rd_valid;
  logic [3:0]    r_key_s1, r_key_sync, r_key_prev;
  logic          r_kready, r_kovr, r_kie;
  logic [9:0]    r_sw_s1, r_sw_sync, r_sw_db, r_sw_cand;
  logic [DW-1:0] r_db_cnt;
  logic [PW-1:0] r_pre;
  logic [31:0]   r_tcnt, r_tlim;
  logic          r_tready, r_tovr, r_tie;
  logic [9:0]    r_led;
  logic [23:0]   r_hex;

  logic          w_hit;
  logic [7:0]    w_off;
  logic [31:0]   w_rd_mux;
  logic          w_wr_kctrl, w_wr_tcnt, w_wr_tlim, w_wr_tctrl, w_wr_led, w_wr_hex;
  logic          w_rd_kdata, w_press, w_tick, w_wrap;
  logic          w_unused;

  assign w_unused = ^addr[1:0];

  assign w_hit = (addr[31:8] == IO_BASE[31:8]);
  assign w_off = {addr[7:2], 2'b00};

  assign w_wr_kctrl = wr_en & w_hit & (w_off == OFF_KCTRL);
  assign w_wr_tcnt  = wr_en & w_hit & (w_off == OFF_TCNT);
  assign w_wr_tlim  = wr_en & w_hit & (w_off == OFF_TLIM);
  assign w_wr_tctrl = wr_en & w_hit & (w_off == OFF_TCTRL);
  assign w_wr_led   = wr_en & w_hit & (w_off == OFF_LEDR);
  assign w_wr_hex   = wr_en & w_hit & (w_off == OFF_HEX);
  assign w_rd_kdata = rd_en & w_hit & (w_off == OFF_KDATA);

  // press = falling edge on any synchronized key
  assign w_press = |(r_key_prev & ~r_key_sync);

  assign w_tick = (r_tlim != 32'd0) && (r_pre == PW'(TICK_CYCLES - 1));
  assign w_wrap = w_tick && (r_tcnt == r_tlim - 32'd1);

  // read mux reflects state before any same-cycle write
  always_comb begin
    w_rd_mux = 32'd0;
    if (w_hit) begin
      case (w_off)
        OFF_KDATA: w_rd_mux = {28'd0, ~r_key_sync};
        OFF_KCTRL: w_rd_mux = {27'd0, r_kie, 2'b00, r_kovr, r_kready};
        OFF_SDATA: w_rd_mux = {22'd0, r_sw_db};
        OFF_TCNT:  w_rd_mux = r_tcnt;
        OFF_TLIM:  w_rd_mux = r_tlim;
        OFF_TCTRL: w_rd_mux = {27'd0, r_tie, 2'b00, r_tovr, r_tready};
        OFF_LEDR:  w_rd_mux = {22'd0, r_led};
        OFF_HEX:   w_rd_mux = {8'd0, r_hex};
        default:   w_rd_mux = 32'd0;
      endcase
    end
  end

  // registered read port
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rdata    <= 32'd0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rdata <= w_rd_mux;
    end
  end

  // key synchronizer and sticky ready/overrun flags; the whole key pipe
  // resets to "released" so reset release never looks like a press
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_key_s1   <= 4'hF;
      r_key_sync <= 4'hF;
      r_key_prev <= 4'hF;
      r_kready   <= 1'b0;
      r_kovr     <= 1'b0;
      r_kie      <= 1'b0;
    end else begin
      r_key_s1   <= KEY;
      r_key_sync <= r_key_s1;
      r_key_prev <= r_key_sync;
      if (w_press)         r_kready <= 1'b1;
      else if (w_rd_kdata) r_kready <= 1'b0;
      if (w_press && r_kready && !w_rd_kdata) r_kovr <= 1'b1;
      else if (w_wr_kctrl && wdata[1])        r_kovr <= 1'b0;
      if (w_wr_kctrl) r_kie <= wdata[4];
    end
  end

  // switch synchronizer and debounce: accept a new value once it has
  // differed from sw_db and held for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sw_s1   <= 10'd0;
      r_sw_sync <= 10'd0;
      r_sw_db   <= 10'd0;
      r_sw_cand <= 10'd0;
      r_db_cnt  <= '0;
    end else begin
      r_sw_s1   <= SW;
      r_sw_sync <= r_sw_s1;
      if (r_sw_sync == r_sw_db) begin
        r_sw_cand <= r_sw_db;
        r_db_cnt  <= '0;
      end else if (r_sw_sync != r_sw_cand) begin
        r_sw_cand <= r_sw_sync;
        r_db_cnt  <= DW'(1);
      end else if (r_db_cnt >= DW'(DEBOUNCE_CYCLES - 1)) begin
        r_sw_db  <= r_sw_sync;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end
    end
  end

  // prescaler, interval counter and timer flags
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pre    <= '0;
      r_tcnt   <= 32'd0;
      r_tlim   <= 32'd0;
      r_tready <= 1'b0;
      r_tovr   <= 1'b0;
      r_tie    <= 1'b0;
    end else begin
      if (w_wr_tcnt || w_wr_tlim) r_pre <= '0;
      else if (r_tlim != 32'd0)   r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (w_wr_tcnt)   r_tcnt <= wdata;
      else if (w_tick) r_tcnt <= w_wrap ? 32'd0 : r_tcnt + 32'd1;
      if (w_wr_tlim) r_tlim <= wdata;
      // a wrap beats a same-cycle software clear
      if (w_wrap)                          r_tready <= 1'b1;
      else if (w_wr_tctrl && !wdata[0])    r_tready <= 1'b0;
      if (w_wrap && r_tready)              r_tovr <= 1'b1;
      else if (w_wr_tctrl && wdata[1])     r_tovr <= 1'b0;
      if (w_wr_tctrl) r_tie <= wdata[4];
    end
  end

  // LED and 7-segment value registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_led <= 10'd0;
      r_hex <= 24'd0;
    end else begin
      if (w_wr_led) r_led <= wdata[9:0];
      if (w_wr_hex) r_hex <= wdata[23:0];
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000; 4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100; 4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001; 4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010; 4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000; 4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000; 4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110; 4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110; default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign HEX0     = seg7(r_hex[3:0]);
  assign HEX1     = seg7(r_hex[7:4]);
  assign HEX2     = seg7(r_hex[11:8]);
  assign HEX3     = seg7(r_hex[15:12]);
  assign HEX4     = seg7(r_hex[19:16]);
  assign HEX5     = seg7(r_hex[23:20]);
  assign LEDR     = r_led;
  assign rdata    = r_rdata;
  assign rd_valid = r_rd_valid;
  assign irq      = (r_kready & r_kie) | (r_tready & r_tie);

endmodule

// File: tb/tb_io_ctrl.sv
// tb_io_ctrl: directed stimulus, cycle model of the register-level
// behaviour, per-cycle output compare plus hand-computed literal checks.
module tb_io_ctrl;
  localparam int TICK = 2;
  localparam int DEB  = 4;
  localparam logic [31:0] BASE = 32'hF000_0000;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [3:0]  KEY = 4'hF;
  logic [9:0]  SW = 10'd0;
  logic [31:0] rdata;
  logic        rd_valid, irq;
  logic [9:0]  LEDR;
  logic [6:0]  hex_o [6];

  int vectors = 0, miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  io_ctrl #(.IO_BASE(BASE), .TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DEB)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .addr(addr), .rd_en(rd_en),
    .wr_en(wr_en), .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid),
    .KEY(KEY), .SW(SW), .LEDR(LEDR),
    .HEX0(hex_o[0]), .HEX1(hex_o[1]), .HEX2(hex_o[2]),
    .HEX3(hex_o[3]), .HEX4(hex_o[4]), .HEX5(hex_o[5]), .irq(irq));

  logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // ---------------- model state ----------------
  logic [3:0]  k_hist [3];   // KEY delayed 1, 2 (= synced), 3 (= previous synced)
  logic [9:0]  s_hist [2];   // SW delayed 1, 2 (= synced)
  logic [9:0]  s_db, s_last;
  int          s_run;
  logic        m_kready, m_kovr, m_kie, m_tready, m_tovr, m_tie, m_rdv;
  logic [31:0] m_tcnt, m_tlim, m_rdata;
  int          m_pre;
  logic [9:0]  m_led;
  logic [23:0] m_hex;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 3; i++) k_hist[i] = 4'hF;
    for (int i = 0; i < 2; i++) s_hist[i] = 10'd0;
    s_db = 0; s_last = 0; s_run = 0;
    m_kready = 0; m_kovr = 0; m_kie = 0; m_tready = 0; m_tovr = 0; m_tie = 0;
    m_rdv = 0; m_tcnt = 0; m_tlim = 0; m_rdata = 0; m_pre = 0; m_led = 0; m_hex = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:8] != BASE[31:8]) return 32'd0;
    case ({a[7:2], 2'b00})
      8'h00: return {28'd0, ~k_hist[1]};
      8'h04: return 32'(m_kie) << 4 | 32'(m_kovr) << 1 | 32'(m_kready);
      8'h10: return {22'd0, s_db};
      8'h20: return m_tcnt;
      8'h24: return m_tlim;
      8'h28: return 32'(m_tie) << 4 | 32'(m_tovr) << 1 | 32'(m_tready);
      8'h30: return {22'd0, m_led};
      8'h34: return {8'd0, m_hex};
      default: return 32'd0;
    endcase
  endfunction

  // one clock of the spec rules, everything decided from pre-edge state
  task automatic m_step();
    logic       inwin = (addr[31:8] == BASE[31:8]);
    logic [7:0] off = {addr[7:2], 2'b00};
    logic       wr = wr_en && inwin;
    logic       rdk = rd_en && inwin && off == 8'h00;
    logic       press = |(k_hist[2] & ~k_hist[1]);
    logic       tick = (m_tlim != 0) && (m_pre == TICK - 1);
    logic       wrap = tick && (m_tcnt == m_tlim - 1);
    logic       old_kready = m_kready, old_tready = m_tready;
    logic [9:0] sync = s_hist[1];
    if (rd_en) m_rdata = m_read(addr);
    m_rdv = rd_en;
    // keys
    m_kready = press ? 1'b1 : (rdk ? 1'b0 : m_kready);
    if (press && old_kready && !rdk) m_kovr = 1;
    else if (wr && off == 8'h04 && wdata[1]) m_kovr = 0;
    if (wr && off == 8'h04) m_kie = wdata[4];
    // timer
    if (wr && (off == 8'h20 || off == 8'h24)) m_pre = 0;
    else if (m_tlim != 0) m_pre = tick ? 0 : m_pre + 1;
    if (wr && off == 8'h20) m_tcnt = wdata;
    else if (tick) m_tcnt = wrap ? 32'd0 : m_tcnt + 1;
    if (wr && off == 8'h24) m_tlim = wdata;
    if (wrap) m_tready = 1;
    else if (wr && off == 8'h28 && !wdata[0]) m_tready = 0;
    if (wrap && old_tready) m_tovr = 1;
    else if (wr && off == 8'h28 && wdata[1]) m_tovr = 0;
    if (wr && off == 8'h28) m_tie = wdata[4];
    if (wr && off == 8'h30) m_led = wdata[9:0];
    if (wr && off == 8'h34) m_hex = wdata[23:0];
    // switches: length of the current run of the synced value
    s_run = (sync == s_last) ? s_run + 1 : 1;
    s_last = sync;
    if (sync != s_db && s_run >= DEB) s_db = sync;
    // synchronizer pipes
    k_hist[2] = k_hist[1]; k_hist[1] = k_hist[0]; k_hist[0] = KEY;
    s_hist[1] = s_hist[0]; s_hist[0] = SW;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_rdv});
      if (m_rdv) chk("rdata", rdata, m_rdata);
      chk("LEDR", {22'd0, LEDR}, {22'd0, m_led});
      chk("irq", {31'd0, irq}, {31'd0, (m_kready & m_kie) | (m_tready & m_tie)});
      for (int i = 0; i < 6; i++)
        chk($sformatf("HEX%0d", i), {25'd0, hex_o[i]}, {25'd0, SEG[m_hex[4*i +: 4]]});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1;
    tick();
    wr_en = 0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; rd_en = 1;
    tick();
    rd_en = 0;
    chk("rd_valid_pulse", {31'd0, rd_valid}, 32'd1);
    d = rdata;
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    chk(name, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    // 1. reset state
    #2 rst_n = 0;
    chk_en = 1;
    tick(3);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rdvalid", {31'd0, rd_valid}, 32'd0);
    chk("rst_hex0", {25'd0, hex_o[0]}, 32'h40);
    chk("rst_hex5", {25'd0, hex_o[5]}, 32'h40);
    chk("rst_ledr", {22'd0, LEDR}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1;
    tick(2);
    read_chk("hex_rst", BASE + 32'h34, 32'd0);
    read_chk("led_rst", BASE + 32'h30, 32'd0);

    // 2. LED / HEX registers
    bus_write(BASE + 32'h34, 32'h000A_5F38);
    bus_write(BASE + 32'h30, 32'h0000_02AA);
    chk("hex0_8", {25'd0, hex_o[0]}, 32'h00);
    chk("hex1_3", {25'd0, hex_o[1]}, 32'h30);
    chk("hex2_F", {25'd0, hex_o[2]}, 32'h0E);
    chk("hex3_5", {25'd0, hex_o[3]}, 32'h12);
    chk("hex4_A", {25'd0, hex_o[4]}, 32'h08);
    chk("hex5_0", {25'd0, hex_o[5]}, 32'h40);
    chk("ledr", {22'd0, LEDR}, 32'h2AA);
    read_chk("hex_rb", BASE + 32'h34, 32'h000A_5F38);
    read_chk("led_rb", BASE + 32'h30, 32'h0000_02AA);

    // 3. keys
    bus_write(BASE + 32'h04, 32'h10);
    KEY = 4'b1011;
    tick(2);
    chk("key_irq_early", {31'd0, irq}, 32'd0);
    tick();
    chk("key_irq", {31'd0, irq}, 32'd1);
    KEY = 4'b1010;
    tick(3);
    read_chk("kctrl_ovr", BASE + 32'h04, 32'h13);
    read_chk("kdata", BASE + 32'h00, 32'h5);
    read_chk("kctrl_clr", BASE + 32'h04, 32'h12);
    chk("key_irq_off", {31'd0, irq}, 32'd0);
    bus_write(BASE + 32'h04, 32'h2);
    read_chk("kctrl_w1c", BASE + 32'h04, 32'h0);
    KEY = 4'hF;
    tick(4);
    read_chk("kctrl_release", BASE + 32'h04, 32'h0);

    // 4. switch debounce
    SW = 10'h3FF;
    tick(3);
    SW = 10'h000;
    tick(6);
    read_chk("sw_glitch", BASE + 32'h10, 32'h0);
    SW = 10'h155;
    tick(6);
    read_chk("sw_db", BASE + 32'h10, 32'h155);

    // 5. timer
    bus_write(BASE + 32'h28, 32'h10);
    bus_write(BASE + 32'h24, 32'd3);
    tick(3);
    read_chk("tcnt_1", BASE + 32'h20, 32'd1);
    tick();
    chk("tmr_irq_early", {31'd0, irq}, 32'd0);
    tick();
    chk("tmr_irq", {31'd0, irq}, 32'd1);
    read_chk("tctrl_rdy", BASE + 32'h28, 32'h11);
    tick(5);
    read_chk("tctrl_ovr", BASE + 32'h28, 32'h13);
    bus_write(BASE + 32'h24, 32'd0);
    tick(4);
    read_chk("tcnt_frozen", BASE + 32'h20, 32'd1);
    tick(3);
    read_chk("tcnt_frozen2", BASE + 32'h20, 32'd1);
    bus_write(BASE + 32'h28, 32'h2);
    read_chk("tctrl_clr", BASE + 32'h28, 32'h0);

    // 6. unmapped / out of window, read+write, reset mid-read
    read_chk("unmapped", BASE + 32'h80, 32'd0);
    read_chk("outside", 32'h0000_0034, 32'd0);
    bus_write(BASE + 32'h80, 32'hFFFF_FFFF);
    bus_write(32'h1000_0030, 32'hFFFF_FFFF);
    read_chk("hex_kept", BASE + 32'h34, 32'h000A_5F38);
    read_chk("led_kept", BASE + 32'h30, 32'h0000_02AA);
    addr = BASE + 32'h30; wdata = 32'h155; wr_en = 1; rd_en = 1;
    tick();
    wr_en = 0; rd_en = 0;
    chk("rw_prewrite", rdata, 32'h2AA);
    read_chk("rw_post", BASE + 32'h30, 32'h155);
    addr = BASE + 32'h30; rd_en = 1;
    #2 rst_n = 0;
    tick();
    rd_en = 0;
    chk("rstrd_valid0", {31'd0, rd_valid}, 32'd0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstrd_valid", {31'd0, rd_valid}, 32'd0);
    end
    chk("rst2_ledr", {22'd0, LEDR}, 32'd0);
    chk("rst2_hex0", {25'd0, hex_o[0]}, 32'h40);
    tick(8);
    read_chk("sw_after_rst", BASE + 32'h10, 32'h155);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
